mode_sched: RTL and testbench

Front-panel mode scheduler for the clock design. It owns the shared push-buttons and the single 48-bit seven-segment display, and it time-shares them between four mode blocks: 0 clock, 1 alarm, 2 stopwatch, 3 timer. It enables exactly one mode block at a time and forwards buttons only to that block. It preempts to the alarm block while the alarm rings, and it falls back to clock mode after an idle timeout.

---
 rtl/mode_sched_if.sv | 24 ++
 rtl/mode_sched.sv | 128 ++++++++++++
 tb/tb_mode_sched.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mode_sched_if.sv
// Front-panel bus between the mode scheduler and the mode blocks / panel I/O.
interface mode_sched_if;
  logic         tick;
  logic         mode_btn;
  logic [5:0]   btn_in;
  logic [3:0]   norm_in;
  logic         alm;
  logic [191:0] disp_in;
  logic [3:0]   mode_en;
  logic [5:0]   btn_out;
  logic [47:0]  disp;
  logic [1:0]   cur_mode;
  logic         ringing;

  modport master (
    output tick, mode_btn, btn_in, norm_in, alm, disp_in,
    input  mode_en, btn_out, disp, cur_mode, ringing
  );

  modport slave (
    input  tick, mode_btn, btn_in, norm_in, alm, disp_in,
    output mode_en, btn_out, disp, cur_mode, ringing
  );
endinterface

// File: rtl/mode_sched.sv
// Front-panel mode scheduler: time-shares buttons and display between four
// mode blocks, preempts to the alarm while it rings, idles back to clock mode.
//
// state  | meaning
// S_RUN  | normal operation, mode_btn cycles modes, idle timeout active
// S_RING | alarm block forced active until alm falls, then restore saved mode
module mode_sched #(
  parameter int unsigned TIMEOUT = 30
) (
  input  logic        clk,
  input  logic        rst_n,
  mode_sched_if.slave bus
);

  localparam logic [0:0] S_RUN  = 1'b0;
  localparam logic [0:0] S_RING = 1'b1;
  localparam logic [5:0] IDLE_LAST = 6'(TIMEOUT - 1);

  logic [0:0] state, state_nxt;
  logic       hold, hold_nxt;
  logic [5:0] idle_cnt, idle_nxt;
  logic [1:0] saved, saved_nxt;
  logic       pend, pend_nxt;
  logic       alm_q, mode_q;
  logic [1:0] cur_mode_r, mode_nxt;
  logic [3:0] mode_en_r;
  logic [5:0] btn_out_r;
  logic       ringing_r;

  logic alm_rise, alm_fall, mode_edge, norm_cur, any_btn, idle_tick, switching;

  assign alm_rise  = bus.alm & ~alm_q;
  assign alm_fall  = ~bus.alm & alm_q;
  assign mode_edge = bus.mode_btn & ~mode_q;
  assign norm_cur  = bus.norm_in[cur_mode_r];
  assign any_btn   = (bus.btn_in != 6'd0) | bus.mode_btn;
  assign idle_tick = bus.tick & (cur_mode_r != 2'd0) & norm_cur;

  always_comb begin
    state_nxt = state;
    mode_nxt  = cur_mode_r;
    saved_nxt = saved;
    pend_nxt  = pend;
    idle_nxt  = idle_cnt;

    if (state == S_RING) begin
      idle_nxt = '0;
      if (alm_fall) begin
        mode_nxt  = saved;
        state_nxt = S_RUN;
      end
    end else begin
      if (any_btn)
        idle_nxt = '0;
      else if (idle_tick)
        idle_nxt = idle_cnt + 6'd1;

      // A pending preemption is dropped once alm falls before it was taken.
      if (alm_rise || (pend && !alm_fall)) begin
        if (norm_cur) begin
          saved_nxt = cur_mode_r;
          mode_nxt  = 2'd1;
          state_nxt = S_RING;
          pend_nxt  = 1'b0;
        end else begin
          pend_nxt = 1'b1;
        end
      end else begin
        pend_nxt = 1'b0;
        if (idle_tick && (idle_cnt == IDLE_LAST))
          mode_nxt = 2'd0;
        else if (mode_edge && norm_cur && !hold)
          mode_nxt = cur_mode_r + 2'd1;
      end
    end

    switching = (mode_nxt != cur_mode_r);
    if (switching)
      idle_nxt = '0;
    // Hold masks buttons after a switch until the panel is fully released.
    hold_nxt = switching ? 1'b1 : (any_btn ? hold : 1'b0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_RUN;
      hold       <= 1'b1;
      idle_cnt   <= '0;
      saved      <= '0;
      pend       <= 1'b0;
      alm_q      <= 1'b0;
      mode_q     <= 1'b0;
      cur_mode_r <= '0;
      mode_en_r  <= 4'b0001;
      btn_out_r  <= '0;
      ringing_r  <= 1'b0;
    end else begin
      state      <= state_nxt;
      hold       <= hold_nxt;
      idle_cnt   <= idle_nxt;
      saved      <= saved_nxt;
      pend       <= pend_nxt;
      alm_q      <= bus.alm;
      mode_q     <= bus.mode_btn;
      cur_mode_r <= mode_nxt;
      mode_en_r  <= 4'b0001 << mode_nxt;
      btn_out_r  <= bus.btn_in & {6{~hold}};
      ringing_r  <= (state_nxt == S_RING);
    end
  end

  always_comb begin
    bus.disp = bus.disp_in[47:0];
    case (cur_mode_r)
      2'd0: bus.disp = bus.disp_in[47:0];
      2'd1: bus.disp = bus.disp_in[95:48];
      2'd2: bus.disp = bus.disp_in[143:96];
      2'd3: bus.disp = bus.disp_in[191:144];
      default: bus.disp = bus.disp_in[47:0];
    endcase
  end

  assign bus.cur_mode = cur_mode_r;
  assign bus.mode_en  = mode_en_r;
  assign bus.btn_out  = btn_out_r;
  assign bus.ringing  = ringing_r;

endmodule

// File: tb/tb_mode_sched.sv
// Self-checking bench for mode_sched: directed vector table, hand-written
// corner sequences, then random stimulus against a behavioural model.
module tb_mode_sched;
  localparam int TO = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  mode_sched_if bus();

  mode_sched #(.TIMEOUT(TO)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model: panel state described as plain integers and flags.
  int         m_mode, m_saved, m_idle;
  bit         m_ring, m_pend, m_hold, m_almq, m_modeq;
  logic [5:0] m_btn;

  function automatic void m_reset();
    m_mode = 0; m_saved = 0; m_idle = 0;
    m_ring = 0; m_pend = 0; m_hold = 1; m_almq = 0; m_modeq = 0;
    m_btn = '0;
  endfunction

  function automatic void m_step();
    bit arise, afall, press, busy, ok, counting;
    int nxt;
    arise = bus.alm && !m_almq;
    afall = !bus.alm && m_almq;
    press = bus.mode_btn && !m_modeq;
    busy  = (bus.btn_in != 0) || bus.mode_btn;
    ok    = bus.norm_in[m_mode];
    counting = bus.tick && (m_mode != 0) && ok;
    nxt   = m_mode;
    m_btn = m_hold ? 6'd0 : bus.btn_in;
    if (m_ring) begin
      m_idle = 0;
      if (afall) begin nxt = m_saved; m_ring = 0; end
    end else begin
      if (arise || (m_pend && bus.alm)) begin
        if (ok) begin m_saved = m_mode; nxt = 1; m_ring = 1; m_pend = 0; end
        else m_pend = 1;
      end else begin
        m_pend = 0;
        if (counting && (m_idle + 1 >= TO)) nxt = 0;
        else if (press && ok && !m_hold) nxt = (m_mode + 1) % 4;
      end
      if (busy) m_idle = 0;
      else if (counting) m_idle = m_idle + 1;
    end
    if (nxt != m_mode) begin m_hold = 1; m_idle = 0; end
    else if (!busy) m_hold = 0;
    m_mode  = nxt;
    m_almq  = bus.alm;
    m_modeq = bus.mode_btn;
  endfunction

  task automatic chk(input string tag, input logic [47:0] got, input logic [47:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_model(input string where);
    logic [191:0] sh;
    sh = bus.disp_in >> (48 * m_mode);
    chk({where, ".cur_mode"}, 48'(bus.cur_mode), 48'(m_mode));
    chk({where, ".mode_en"},  48'(bus.mode_en), 48'(4'b0001 << m_mode));
    chk({where, ".btn_out"},  48'(bus.btn_out), 48'(m_btn));
    chk({where, ".ringing"},  48'(bus.ringing), 48'(m_ring));
    chk({where, ".disp"},     bus.disp, sh[47:0]);
  endtask

  task automatic cyc(input string where);
    @(posedge clk);
    m_step();
    @(negedge clk);
    check_model(where);
  endtask

  task automatic set_in(input logic [5:0] b, input logic mb, input logic [3:0] n,
                        input logic a, input logic t);
    bus.btn_in = b; bus.mode_btn = mb; bus.norm_in = n; bus.alm = a; bus.tick = t;
  endtask

  typedef struct {
    logic [5:0] btn;
    logic       mb;
    logic [3:0] norm;
    logic       alm;
    logic       tick;
    logic [1:0] em;
    logic [5:0] eb;
    logic       er;
  } vec_t;

  function automatic vec_t mk(logic [5:0] b, logic mb, logic [3:0] n, logic a, logic t,
                              logic [1:0] em, logic [5:0] eb, logic er);
    vec_t r;
    r.btn = b; r.mb = mb; r.norm = n; r.alm = a; r.tick = t;
    r.em = em; r.eb = eb; r.er = er;
    return r;
  endfunction

  localparam logic [5:0] UP    = 6'b100000;
  localparam logic [5:0] ENTER = 6'b000010;
  localparam logic [5:0] ESC   = 6'b000001;

  vec_t tbl[24];

  initial begin
    //           btn  mb norm   alm tick  mode  btn_out ring
    tbl[0]  = mk(0,   0, 4'hF,  0,  0,    0,    0,   0);
    tbl[1]  = mk(0,   0, 4'hF,  0,  0,    0,    0,   0);
    tbl[2]  = mk(0,   1, 4'hF,  0,  0,    1,    0,   0);
    tbl[3]  = mk(0,   1, 4'hF,  0,  0,    1,    0,   0);
    tbl[4]  = mk(0,   0, 4'hF,  0,  0,    1,    0,   0);
    tbl[5]  = mk(UP,  0, 4'hF,  0,  0,    1,    UP,  0);
    tbl[6]  = mk(0,   0, 4'hF,  0,  0,    1,    0,   0);
    tbl[7]  = mk(0,   1, 4'hD,  0,  0,    1,    0,   0);
    tbl[8]  = mk(0,   1, 4'hF,  0,  0,    1,    0,   0);
    tbl[9]  = mk(0,   0, 4'hF,  0,  0,    1,    0,   0);
    tbl[10] = mk(0,   1, 4'hF,  0,  0,    2,    0,   0);
    tbl[11] = mk(0,   0, 4'hF,  0,  0,    2,    0,   0);
    tbl[12] = mk(0,   0, 4'hF,  1,  0,    1,    0,   1);
    tbl[13] = mk(ESC, 0, 4'hF,  1,  0,    1,    0,   1);
    tbl[14] = mk(0,   0, 4'hF,  1,  0,    1,    0,   1);
    tbl[15] = mk(ESC, 0, 4'hF,  1,  0,    1,    ESC, 1);
    tbl[16] = mk(0,   0, 4'hF,  0,  0,    2,    0,   0);
    tbl[17] = mk(0,   0, 4'hF,  0,  0,    2,    0,   0);
    tbl[18] = mk(0,   0, 4'hF,  0,  1,    2,    0,   0);
    tbl[19] = mk(0,   0, 4'hF,  0,  1,    2,    0,   0);
    tbl[20] = mk(UP,  0, 4'hF,  0,  0,    2,    UP,  0);
    tbl[21] = mk(0,   0, 4'hF,  0,  1,    2,    0,   0);
    tbl[22] = mk(0,   0, 4'hF,  0,  1,    2,    0,   0);
    tbl[23] = mk(0,   0, 4'hF,  0,  1,    0,    0,   0);

    set_in(0, 0, 4'hF, 0, 0);
    bus.disp_in = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    m_reset();

    repeat (2) @(negedge clk);
    chk("reset.cur_mode", 48'(bus.cur_mode), 48'd0);
    chk("reset.mode_en",  48'(bus.mode_en),  48'd1);
    chk("reset.btn_out",  48'(bus.btn_out),  48'd0);
    chk("reset.ringing",  48'(bus.ringing),  48'd0);
    check_model("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 24; i++) begin
      set_in(tbl[i].btn, tbl[i].mb, tbl[i].norm, tbl[i].alm, tbl[i].tick);
      cyc("tbl");
      chk($sformatf("tbl[%0d].cur_mode", i), 48'(bus.cur_mode), 48'(tbl[i].em));
      chk($sformatf("tbl[%0d].mode_en", i),  48'(bus.mode_en),  48'(4'b0001 << tbl[i].em));
      chk($sformatf("tbl[%0d].btn_out", i),  48'(bus.btn_out),  48'(tbl[i].eb));
      chk($sformatf("tbl[%0d].ringing", i),  48'(bus.ringing),  48'(tbl[i].er));
    end

    // Long mode_btn hold advances exactly once.
    set_in(0, 0, 4'hF, 0, 0); cyc("hold0");
    set_in(0, 1, 4'hF, 0, 0); cyc("hold1");
    chk("hold.first", 48'(bus.cur_mode), 48'd1);
    set_in(0, 0, 4'hF, 0, 0); cyc("hold2");
    set_in(0, 1, 4'hF, 0, 0);
    for (int i = 0; i < 10; i++) cyc("hold_long");
    chk("hold.once", 48'(bus.cur_mode), 48'd2);
    set_in(0, 0, 4'hF, 0, 0); cyc("hold3");

    // Button held across a switch stays masked until the panel is released.
    set_in(ENTER, 0, 4'hF, 0, 0); cyc("mask0");
    chk("mask.enter_fwd", 48'(bus.btn_out), 48'(ENTER));
    set_in(ENTER, 1, 4'hF, 0, 0); cyc("mask1");
    chk("mask.switch", 48'(bus.cur_mode), 48'd3);
    for (int i = 0; i < 3; i++) cyc("mask_both");
    chk("mask.both_held", 48'(bus.btn_out), 48'd0);
    set_in(ENTER, 0, 4'hF, 0, 0); cyc("mask2"); cyc("mask2");
    chk("mask.enter_held", 48'(bus.btn_out), 48'd0);
    set_in(0, 0, 4'hF, 0, 0); cyc("mask3");
    set_in(UP, 0, 4'hF, 0, 0); cyc("mask4");
    chk("mask.up_fwd", 48'(bus.btn_out), 48'(UP));
    set_in(0, 0, 4'hF, 0, 0); cyc("mask5");

    // Idle timeout in mode 3 with a restart at the second tick.
    set_in(0, 0, 4'hF, 0, 1); cyc("to_t1");
    set_in(0, 0, 4'hF, 0, 0); cyc("to_gap");
    set_in(UP, 0, 4'hF, 0, 1); cyc("to_t2_press");
    set_in(0, 0, 4'hF, 0, 1); cyc("to_t3");
    set_in(0, 0, 4'hF, 0, 0); cyc("to_gap");
    set_in(0, 0, 4'hF, 0, 1); cyc("to_t4");
    chk("timeout.restarted", 48'(bus.cur_mode), 48'd3);
    set_in(0, 0, 4'hF, 0, 1); cyc("to_t5");
    chk("timeout.fired", 48'(bus.cur_mode), 48'd0);
    set_in(0, 0, 4'hF, 0, 0); cyc("to_end");

    // Preemption deferred while the current block is editing.
    for (int i = 0; i < 2; i++) begin
      set_in(0, 1, 4'hF, 0, 0); cyc("pre_go");
      set_in(0, 0, 4'hF, 0, 0); cyc("pre_go");
    end
    chk("defer.start", 48'(bus.cur_mode), 48'd2);
    set_in(0, 0, 4'hB, 1, 0);
    for (int i = 0; i < 3; i++) cyc("defer_wait");
    chk("defer.no_preempt", 48'(bus.ringing), 48'd0);
    set_in(0, 0, 4'hF, 1, 0); cyc("defer_take");
    chk("defer.mode", 48'(bus.cur_mode), 48'd1);
    chk("defer.ring", 48'(bus.ringing), 48'd1);
    set_in(0, 0, 4'hF, 0, 0); cyc("defer_restore");
    chk("restore.mode", 48'(bus.cur_mode), 48'd2);

    // Asynchronous reset in the middle of RING.
    set_in(0, 0, 4'hF, 1, 0); cyc("ring_again");
    chk("ring_again.ring", 48'(bus.ringing), 48'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst.cur_mode", 48'(bus.cur_mode), 48'd0);
    chk("async_rst.mode_en",  48'(bus.mode_en),  48'd1);
    chk("async_rst.btn_out",  48'(bus.btn_out),  48'd0);
    chk("async_rst.ringing",  48'(bus.ringing),  48'd0);
    m_reset();
    set_in(0, 0, 4'hF, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc("post_rst");

    // Random traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 19) == 0) bus.norm_in = 4'($urandom) | 4'($urandom);
      if ($urandom_range(0, 39) == 0) bus.alm = ~bus.alm;
      if ($urandom_range(0, 3) == 0)  bus.mode_btn = ~bus.mode_btn;
      bus.btn_in = ($urandom_range(0, 7) == 0) ? 6'($urandom) : 6'd0;
      bus.tick = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 9) == 0)
        bus.disp_in = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      cyc("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
